// File: rtl/spi_matrix_rx.sv
// SPI mode-0 receiver for one LED-matrix lane: oversampled, deserialised,
// framed into BYTES_PER_MATRIX-byte images with framing/overrun flags.
module spi_matrix_rx #(
    parameter int BYTES_PER_MATRIX = 384,
    parameter int SYNC_STAGES      = 2,
    localparam int IW = $clog2(BYTES_PER_MATRIX),
    localparam int CW = $clog2(BYTES_PER_MATRIX + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          spi_clk_in,
    input  logic          spi_mosi_in,
    input  logic          cs_n_in,
    output logic [7:0]    rx_data,
    output logic          rx_valid,
    input  logic          rx_ready,
    output logic [IW-1:0] byte_index,
    output logic          frame_start,
    output logic          frame_done,
    output logic          frame_err,
    output logic          overrun_err
);

    typedef enum logic [1:0] {ST_IDLE, ST_RECV, ST_FULL} state_t;

    state_t                 r_state, w_next;
    logic [SYNC_STAGES-1:0] r_sclk_sync, r_mosi_sync, r_cs_sync;
    logic                   r_sclk_d, r_cs_d;
    logic [7:0]             r_shift, r_rx_data;
    logic [2:0]             r_bit_cnt;
    logic [CW-1:0]          r_byte_cnt;
    logic [IW-1:0]          r_byte_index;
    logic                   r_byte_done, r_extra, r_rx_valid;
    logic                   r_frame_start, r_frame_done, r_frame_err, r_overrun;

    logic w_sclk_rise, w_cs_fall, w_cs_rise, w_mosi, w_last_done, w_pending;
    logic w_start, w_done, w_ferr, w_shift, w_extra;

    assign w_sclk_rise = r_sclk_sync[SYNC_STAGES-1] & ~r_sclk_d;
    assign w_cs_fall   = ~r_cs_sync[SYNC_STAGES-1] & r_cs_d;
    assign w_cs_rise   = r_cs_sync[SYNC_STAGES-1] & ~r_cs_d;
    assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
    assign w_last_done = r_byte_done &&
                         (r_byte_cnt == CW'(BYTES_PER_MATRIX - 1));
    assign w_pending   = r_rx_valid && !rx_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclk_sync <= '0;
            r_mosi_sync <= '0;
            r_cs_sync   <= '1;
            r_sclk_d    <= 1'b0;
            r_cs_d      <= 1'b1;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi_clk_in};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi_in};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs_n_in};
            r_sclk_d    <= r_sclk_sync[SYNC_STAGES-1];
            r_cs_d      <= r_cs_sync[SYNC_STAGES-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // cs_n release takes priority over a coincident sclk rise.
    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        w_done  = 1'b0;
        w_ferr  = 1'b0;
        w_shift = 1'b0;
        w_extra = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_cs_fall) begin
                    w_next  = ST_RECV;
                    w_start = 1'b1;
                end
            end
            ST_RECV: begin
                if (w_cs_rise) begin
                    w_next = ST_IDLE;
                    if (w_last_done && r_bit_cnt == 3'd0) w_done = 1'b1;
                    else                                  w_ferr = 1'b1;
                end else if (w_last_done) begin
                    w_next  = ST_FULL;
                    w_extra = w_sclk_rise;
                end else begin
                    w_shift = w_sclk_rise;
                end
            end
            ST_FULL: begin
                if (w_cs_rise) begin
                    w_next = ST_IDLE;
                    if (!r_extra) w_done = 1'b1;
                    else          w_ferr = 1'b1;
                end else begin
                    w_extra = w_sclk_rise;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift       <= '0;
            r_bit_cnt     <= '0;
            r_byte_cnt    <= '0;
            r_byte_done   <= 1'b0;
            r_extra       <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_done  <= 1'b0;
            r_frame_err   <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_frame_start <= w_start;
            r_frame_done  <= w_done;
            if (w_start) begin
                r_bit_cnt   <= '0;
                r_byte_cnt  <= '0;
                r_byte_done <= 1'b0;
                r_extra     <= 1'b0;
                r_frame_err <= 1'b0;
                r_overrun   <= 1'b0;
            end else begin
                if (w_ferr || w_extra) r_frame_err <= 1'b1;
                if (w_extra)           r_extra     <= 1'b1;
                if (w_shift) begin
                    r_shift   <= {r_shift[6:0], w_mosi};
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                end
                r_byte_done <= w_shift && (r_bit_cnt == 3'd7);
                if (r_byte_done) begin
                    r_byte_cnt <= r_byte_cnt + CW'(1);
                    if (w_pending) r_overrun <= 1'b1;
                end
            end
        end
    end

    // A pending byte is never overwritten; a colliding byte is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_data    <= '0;
            r_byte_index <= '0;
            r_rx_valid   <= 1'b0;
        end else if (r_byte_done && !w_pending) begin
            r_rx_data    <= r_shift;
            r_byte_index <= r_byte_cnt[IW-1:0];
            r_rx_valid   <= 1'b1;
        end else if (rx_ready) begin
            r_rx_valid   <= 1'b0;
        end
    end

    assign rx_data     = r_rx_data;
    assign rx_valid    = r_rx_valid;
    assign byte_index  = r_byte_index;
    assign frame_start = r_frame_start;
    assign frame_done  = r_frame_done;
    assign frame_err   = r_frame_err;
    assign overrun_err = r_overrun;

endmodule

// File: tb/tb_spi_matrix_rx.sv
// Self-checking bench for spi_matrix_rx: frame vectors from a table,
// scoreboard of expected beats, hand sequences for overrun and reset.
module tb_spi_matrix_rx;
    localparam int BPM = 384;
    localparam int IW  = $clog2(BPM);

    logic          clk = 1'b0;
    logic          rst_n, sclk, mosi, cs_n;
    logic          rx_ready = 1'b0;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic [IW-1:0] byte_index;
    logic          frame_start, frame_done, frame_err, overrun_err;

    spi_matrix_rx #(.BYTES_PER_MATRIX(BPM), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .spi_clk_in(sclk), .spi_mosi_in(mosi),
        .cs_n_in(cs_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .byte_index(byte_index),
        .frame_start(frame_start), .frame_done(frame_done),
        .frame_err(frame_err), .overrun_err(overrun_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int nb; int xb; bit rnd; int hp; int rmode;
        bit exp_done; bit exp_ferr;
    } vec_t;
    typedef struct { logic [7:0] d; logic [IW-1:0] idx; } beat_t;

    beat_t      exp_q[$];
    logic [7:0] obs_d [0:4095];
    logic [IW-1:0] obs_i [0:4095];
    int obs_cnt = 0;
    int n_fs = 0;
    int n_fd = 0;
    int rd = 0;
    int n_cmp = 0;
    int n_err = 0;
    int rdy_mode = 1;

    // A beat is recorded when valid&&ready hold ahead of the next edge.
    always @(negedge clk) begin
        if (rx_valid && rx_ready && obs_cnt < 4096) begin
            obs_d[obs_cnt] <= rx_data;
            obs_i[obs_cnt] <= byte_index;
            obs_cnt <= obs_cnt + 1;
        end
        if (frame_start) n_fs <= n_fs + 1;
        if (frame_done)  n_fd <= n_fd + 1;
    end

    initial begin
        int wait_c;
        wait_c = 0;
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0: rx_ready = 1'b0;
                1: rx_ready = 1'b1;
                default: begin
                    if (rx_valid) wait_c++;
                    else          wait_c = 0;
                    rx_ready = (wait_c >= 5) || ($urandom_range(0, 3) == 0);
                end
            endcase
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic spi_bit(input logic b, input int hp);
        mosi = b;
        tick(hp);
        sclk = 1'b1;
        tick(hp);
        sclk = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int hp);
        for (int k = 7; k >= 0; k--) spi_bit(b[k], hp);
    endtask

    task automatic drain();
        beat_t e;
        while (rd < obs_cnt) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexp_beat: got idx %0d data %0h expected none",
                         obs_i[rd], obs_d[rd]);
            end else begin
                e = exp_q.pop_front();
                chk("beat", {obs_i[rd], obs_d[rd]}, {e.idx, e.d});
            end
            rd++;
        end
    endtask

    task automatic run_vector(input vec_t v);
        int s0, d0, b0;
        logic [7:0] dat;
        drain();
        s0 = n_fs;
        d0 = n_fd;
        b0 = obs_cnt;
        rdy_mode = v.rmode;
        cs_n = 1'b0;
        tick(6);
        chk("ferr_clr", frame_err, 0);
        chk("ovr_clr", overrun_err, 0);
        for (int i = 0; i < v.nb; i++) begin
            dat = v.rnd ? 8'($urandom_range(0, 255)) : 8'(i & 8'h7F);
            exp_q.push_back('{d: dat, idx: IW'(i)});
            send_byte(dat, v.hp);
        end
        for (int j = 0; j < v.xb; j++) spi_bit(1'($urandom_range(0, 1)), v.hp);
        tick(3);
        cs_n = 1'b1;
        tick(30);
        drain();
        chk("beats", obs_cnt - b0, v.nb);
        chk("frame_start", n_fs - s0, 1);
        chk("frame_done", n_fd - d0, 32'(v.exp_done));
        chk("frame_err", frame_err, 32'(v.exp_ferr));
        chk("overrun", overrun_err, 0);
        chk("sb_left", exp_q.size(), 0);
    endtask

    initial begin
        vec_t vecs[4];
        int d0;
        vecs[0] = '{384, 0, 1'b0, 2, 1, 1'b1, 1'b0};
        vecs[1] = '{10,  3, 1'b1, 3, 1, 1'b0, 1'b1};
        vecs[2] = '{384, 8, 1'b1, 2, 1, 1'b0, 1'b1};
        vecs[3] = '{384, 0, 1'b1, 2, 2, 1'b1, 1'b0};

        rst_n = 1'b0;
        cs_n  = 1'b1;
        sclk  = 1'b0;
        mosi  = 1'b0;
        @(negedge clk);
        chk("reset_outs", {rx_data, rx_valid, byte_index, frame_start,
                           frame_done, frame_err, overrun_err}, 0);
        tick(2);
        rst_n = 1'b1;
        tick(5);

        for (int v = 0; v < 4; v++) run_vector(vecs[v]);

        // Overrun: second byte arrives while the first is still pending.
        drain();
        rdy_mode = 0;
        cs_n = 1'b0;
        tick(6);
        chk("t2_ferr_clr", frame_err, 0);
        exp_q.push_back('{d: 8'hA5, idx: IW'(0)});
        send_byte(8'hA5, 3);
        send_byte(8'h3C, 3);
        tick(10);
        chk("t2_hold", {rx_valid, byte_index, rx_data}, {1'b1, IW'(0), 8'hA5});
        chk("t2_overrun", overrun_err, 1);
        rdy_mode = 1;
        tick(5);
        drain();
        exp_q.push_back('{d: 8'h11, idx: IW'(2)});
        send_byte(8'h11, 3);
        tick(3);
        cs_n = 1'b1;
        tick(30);
        drain();
        chk("t2_sb_left", exp_q.size(), 0);
        chk("t2_ferr", frame_err, 1);
        chk("t2_ovr_sticky", overrun_err, 1);

        // Asynchronous reset in the middle of byte 100.
        d0 = n_fd;
        cs_n = 1'b0;
        tick(6);
        for (int i = 0; i < 100; i++) begin
            exp_q.push_back('{d: 8'(i * 3 + 1), idx: IW'(i)});
            send_byte(8'(i * 3 + 1), 2);
        end
        for (int j = 0; j < 4; j++) spi_bit(1'b1, 2);
        rst_n = 1'b0;
        cs_n  = 1'b1;
        sclk  = 1'b0;
        @(negedge clk);
        chk("t5_rst_outs", {rx_data, rx_valid, byte_index, frame_start,
                            frame_done, frame_err, overrun_err}, 0);
        tick(1);
        rst_n = 1'b1;
        tick(10);
        drain();
        chk("t5_sb_left", exp_q.size(), 0);
        chk("t5_no_done", n_fd - d0, 0);
        run_vector(vecs[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
